cachebusarb: RTL and testbench

Two-port bus arbiter and burst sequencer between the instruction cache, the data cache, and a single line-fill memory port. It samples each cache's `CacheBusRW` request and grants one requester. It then runs a `LINELEN/AHBW`-beat burst: line fill into a shared `FetchBuffer`, or dirty-line writeback from the granted cache's `ReadDataWord`. It drives the `BeatCount`/`SelBusBeat`/`CacheBusAck` handshake that the cache FSM expects.

---
 rtl/cachebusarb.sv | 129 ++++++++++++
 tb/tb_cachebusarb.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cachebusarb.sv
// cachebusarb: arbitrates I$/D$ line requests onto one memory port and
// sequences the beats of a line fill or dirty-line writeback.
module cachebusarb #(
    parameter int PA_BITS = 56,
    parameter int AHBW    = 64,
    parameter int LINELEN = 512
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [1:0]                    IFUCacheBusRW,
    input  logic [PA_BITS-1:0]            IFUCacheBusAdr,
    output logic                          IFUCacheBusAck,
    output logic                          IFUSelBusBeat,
    input  logic [1:0]                    LSUCacheBusRW,
    input  logic [PA_BITS-1:0]            LSUCacheBusAdr,
    input  logic [AHBW-1:0]               LSUWriteData,
    output logic                          LSUCacheBusAck,
    output logic                          LSUSelBusBeat,
    output logic [$clog2(LINELEN/AHBW)-1:0] BeatCount,
    output logic [LINELEN-1:0]            FetchBuffer,
    output logic                          MemReq,
    output logic                          MemWrite,
    output logic [PA_BITS-1:0]            MemAdr,
    output logic [AHBW-1:0]               MemWData,
    input  logic [AHBW-1:0]               MemRData,
    input  logic                          MemReady
);
    localparam int BEATS     = LINELEN / AHBW;
    localparam int LOGBWPL   = $clog2(BEATS);
    localparam int OFFSETLEN = $clog2(LINELEN / 8);
    localparam int BOFF      = $clog2(AHBW / 8);
    localparam int BASEW     = PA_BITS - OFFSETLEN;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BURST = 2'd1;
    localparam logic [1:0] S_ACK   = 2'd2;

    logic [1:0]         state_q, state_d;
    logic               grant_lsu_q, grant_lsu_d;
    logic               op_q, op_d;           // 1 = writeback
    logic [BASEW-1:0]   base_q, base_d;
    logic [LOGBWPL-1:0] beat_q, beat_d;
    logic               last_lsu_q, last_lsu_d;
    logic [LINELEN-1:0] fb_q, fb_d;

    logic ifu_pend, lsu_pend, pick_lsu, in_burst, in_ack;

    // The I$ never writes and only line-aligned address bits matter.
    logic unused_bits;
    assign unused_bits = ^{IFUCacheBusRW[0], IFUCacheBusAdr[OFFSETLEN-1:0],
                           LSUCacheBusAdr[OFFSETLEN-1:0]};

    assign ifu_pend = IFUCacheBusRW[1];
    assign lsu_pend = |LSUCacheBusRW;
    // On contention the requester not served last wins.
    assign pick_lsu = lsu_pend && (!ifu_pend || !last_lsu_q);

    // Next-state: arbitration in IDLE, beat sequencing in BURST.
    always_comb begin
        state_d     = state_q;
        grant_lsu_d = grant_lsu_q;
        op_d        = op_q;
        base_d      = base_q;
        beat_d      = beat_q;
        last_lsu_d  = last_lsu_q;
        fb_d        = fb_q;
        case (state_q)
            S_IDLE: begin
                if (ifu_pend || lsu_pend) begin
                    grant_lsu_d = pick_lsu;
                    op_d        = pick_lsu & LSUCacheBusRW[0];
                    base_d      = pick_lsu ? LSUCacheBusAdr[PA_BITS-1:OFFSETLEN]
                                           : IFUCacheBusAdr[PA_BITS-1:OFFSETLEN];
                    beat_d      = '0;
                    state_d     = S_BURST;
                end
            end
            S_BURST: begin
                if (MemReady) begin
                    if (!op_q)
                        fb_d[int'(beat_q)*AHBW +: AHBW] = MemRData;
                    if (beat_q == LOGBWPL'(BEATS - 1)) begin
                        state_d    = S_ACK;
                        last_lsu_d = grant_lsu_q;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset aborts any burst and clears the fill line.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            grant_lsu_q <= 1'b0;
            op_q        <= 1'b0;
            base_q      <= '0;
            beat_q      <= '0;
            last_lsu_q  <= 1'b0;
            fb_q        <= '0;
        end else begin
            state_q     <= state_d;
            grant_lsu_q <= grant_lsu_d;
            op_q        <= op_d;
            base_q      <= base_d;
            beat_q      <= beat_d;
            last_lsu_q  <= last_lsu_d;
            fb_q        <= fb_d;
        end
    end

    // Outputs decode from registered state only, so reset zeroes them at once.
    assign in_burst       = (state_q == S_BURST);
    assign in_ack         = (state_q == S_ACK);
    assign MemReq         = in_burst;
    assign MemWrite       = in_burst & op_q;
    assign MemAdr         = in_burst ? {base_q, beat_q, {BOFF{1'b0}}} : '0;
    assign MemWData       = in_burst ? LSUWriteData : '0;
    assign IFUSelBusBeat  = in_burst & ~grant_lsu_q;
    assign LSUSelBusBeat  = in_burst &  grant_lsu_q;
    assign IFUCacheBusAck = in_ack & ~grant_lsu_q;
    assign LSUCacheBusAck = in_ack &  grant_lsu_q;
    assign BeatCount      = beat_q;
    assign FetchBuffer    = fb_q;
endmodule

// File: tb/tb_cachebusarb.sv
// Scoreboard bench for cachebusarb: the driver predicts each burst from the
// arbitration rules and queues expected beats/acks; a monitor checks them.
module tb_cachebusarb;
    localparam int PA = 56;
    localparam int AW = 64;
    localparam int LL = 512;
    localparam int NB = LL / AW;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]    ifu_rw, lsu_rw;
    logic [PA-1:0] ifu_adr, lsu_adr;
    logic [31:0]   lsu_tag;
    logic          IFUCacheBusAck, IFUSelBusBeat, LSUCacheBusAck, LSUSelBusBeat;
    logic [2:0]    BeatCount;
    logic [LL-1:0] FetchBuffer;
    logic          MemReq, MemWrite, MemReady;
    logic [PA-1:0] MemAdr;
    logic [AW-1:0] MemWData, MemRData, LSUWriteData;

    function automatic logic [63:0] rfun(input logic [55:0] a);
        return {a[31:0] ^ 32'h5A5A_C3C3, ~a[31:0]};
    endfunction

    assign LSUWriteData = {lsu_tag, 29'd0, BeatCount};
    assign MemRData     = rfun(MemAdr);

    cachebusarb #(.PA_BITS(PA), .AHBW(AW), .LINELEN(LL)) dut (
        .clk(clk), .resetn(resetn),
        .IFUCacheBusRW(ifu_rw), .IFUCacheBusAdr(ifu_adr),
        .IFUCacheBusAck(IFUCacheBusAck), .IFUSelBusBeat(IFUSelBusBeat),
        .LSUCacheBusRW(lsu_rw), .LSUCacheBusAdr(lsu_adr), .LSUWriteData(LSUWriteData),
        .LSUCacheBusAck(LSUCacheBusAck), .LSUSelBusBeat(LSUSelBusBeat),
        .BeatCount(BeatCount), .FetchBuffer(FetchBuffer),
        .MemReq(MemReq), .MemWrite(MemWrite), .MemAdr(MemAdr), .MemWData(MemWData),
        .MemRData(MemRData), .MemReady(MemReady)
    );

    typedef struct {
        logic [55:0] adr;
        logic        wr;
        logic [63:0] wd;
        logic        lsu;
        logic [2:0]  beat;
    } beat_t;
    typedef struct {
        logic          lsu;
        logic [LL-1:0] line;
    } ack_t;
    beat_t bq[$];
    ack_t  aq[$];

    int n_chk = 0;
    int n_fail = 0;
    int rmode = 0;        // 0 random ready, 1 always ready, 2 alternate
    bit mon_en = 1'b0;
    bit m_last_lsu = 1'b0;
    logic [LL-1:0] m_fb = '0;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [55:0] rand56();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[55:0];
    endfunction

    // Memory-side ready pattern, changed just after each rising edge.
    initial begin
        MemReady = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0:       MemReady = ($urandom % 4) != 0;
                1:       MemReady = 1'b1;
                default: MemReady = ~MemReady;
            endcase
        end
    end

    // Monitor: compare every presented beat and ack against the queues.
    always @(negedge clk) begin
        beat_t b;
        ack_t  a;
        if (resetn && mon_en) begin
            if (MemReq) begin
                if (bq.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_beat: got adr %0h expected none", MemAdr);
                end else begin
                    b = bq[0];
                    chk("mem_adr",   512'(MemAdr),        512'(b.adr));
                    chk("mem_write", 512'(MemWrite),      512'(b.wr));
                    chk("beatcount", 512'(BeatCount),     512'(b.beat));
                    chk("lsu_sel",   512'(LSUSelBusBeat), 512'(b.lsu));
                    chk("ifu_sel",   512'(IFUSelBusBeat), 512'(!b.lsu));
                    if (b.wr) chk("mem_wdata", 512'(MemWData), 512'(b.wd));
                    if (MemReady) void'(bq.pop_front());
                end
            end
            if (IFUCacheBusAck || LSUCacheBusAck) begin
                chk("ack_memreq", 512'(MemReq), 512'(0));
                chk("ack_sel", 512'({IFUSelBusBeat, LSUSelBusBeat}), 512'(0));
                if (aq.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_ack: got %0d%0d expected none", IFUCacheBusAck, LSUCacheBusAck);
                end else begin
                    a = aq.pop_front();
                    chk("ack_who", 512'({IFUCacheBusAck, LSUCacheBusAck}), 512'({!a.lsu, a.lsu}));
                    chk("fetchbuf", FetchBuffer, a.line);
                end
            end
        end
    end

    // Predict one burst from the current requests, then run it to its ack.
    // k = cycles from request setup (at a negedge) to first MemReq.
    task automatic do_txn(input int k);
        bit ip, lp, g, op, got;
        logic [49:0]   base;
        logic [LL-1:0] line;
        beat_t b;
        int cyc, first, waits;
        ip = ifu_rw[1];
        lp = (lsu_rw != 2'b00);
        g  = lp && (!ip || !m_last_lsu);
        op = g && lsu_rw[0];
        base = g ? lsu_adr[55:6] : ifu_adr[55:6];
        line = m_fb;
        for (int i = 0; i < NB; i++) begin
            b.adr  = {base, 6'd0} + 56'(i * 8);
            b.wr   = op;
            b.wd   = {lsu_tag, 29'd0, 3'(i)};
            b.lsu  = g;
            b.beat = 3'(i);
            bq.push_back(b);
            if (!op) line[i*64 +: 64] = rfun(b.adr);
        end
        aq.push_back('{g, line});
        cyc = 0; first = -1; waits = 0; got = 1'b0;
        while (!got && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (MemReq && first < 0) first = cyc;
            if (MemReq && !MemReady) waits++;
            if (IFUCacheBusAck || LSUCacheBusAck) got = 1'b1;
        end
        if (!got) begin
            n_chk++; n_fail++;
            $display("FAIL ack_timeout: got no ack in %0d cycles expected one", cyc);
            $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
            $finish;
        end
        chk("arb_latency", 512'(first), 512'(k));
        chk("burst_len", 512'(cyc - first), 512'(NB + waits));
        m_last_lsu = g;
        m_fb = line;
        if (g) lsu_rw = 2'b00; else ifu_rw = 2'b00;
    endtask

    task automatic new_lsu(input logic [1:0] rw);
        lsu_rw  = rw;
        lsu_adr = rand56();
        lsu_tag = $urandom;
    endtask

    task automatic reset_mid_burst();
        int n;
        mon_en = 1'b0;
        ifu_rw = 2'b00;
        new_lsu(2'b10);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(MemReq && BeatCount == 3'd3) && n < 100);
        chk("reach_beat3", 512'(MemReq && BeatCount == 3'd3), 512'(1));
        #1 resetn = 1'b0;
        #1;
        chk("rst_memreq", 512'(MemReq), 512'(0));
        chk("rst_memwrite", 512'(MemWrite), 512'(0));
        chk("rst_memadr", 512'(MemAdr), 512'(0));
        chk("rst_memwdata", 512'(MemWData), 512'(0));
        chk("rst_sel", 512'({IFUSelBusBeat, LSUSelBusBeat}), 512'(0));
        chk("rst_ack", 512'({IFUCacheBusAck, LSUCacheBusAck}), 512'(0));
        chk("rst_beat", 512'(BeatCount), 512'(0));
        chk("rst_fb", FetchBuffer, 512'(0));
        bq.delete();
        aq.delete();
        m_last_lsu = 1'b0;
        m_fb = '0;
        lsu_rw = 2'b00;
        @(negedge clk);
        resetn = 1'b1;
        mon_en = 1'b1;
    endtask

    initial begin
        ifu_rw = 2'b00; lsu_rw = 2'b00; ifu_adr = '0; lsu_adr = '0; lsu_tag = '0;
        repeat (3) @(negedge clk);
        chk("reset_memreq", 512'(MemReq), 512'(0));
        chk("reset_beat", 512'(BeatCount), 512'(0));
        chk("reset_fb", FetchBuffer, 512'(0));
        chk("reset_adr", 512'(MemAdr), 512'(0));
        resetn = 1'b1;
        mon_en = 1'b1;

        // IFU RW=01 is not a request.
        @(negedge clk);
        ifu_rw = 2'b01;
        repeat (6) begin
            @(negedge clk);
            chk("ifu01_no_req", 512'(MemReq), 512'(0));
        end
        ifu_rw = 2'b00;
        @(negedge clk);

        // Contention after reset (LSU first), zero-wait I$ fill, round-robin.
        rmode = 1;
        ifu_rw = 2'b10;
        ifu_adr = 56'h80000040;
        new_lsu(2'b10);
        do_txn(1);
        new_lsu(2'b10);
        do_txn(2);
        do_txn(2);

        // D$ writeback with alternating wait states, then RW=11 as write.
        rmode = 2;
        new_lsu(2'b01);
        do_txn(2);
        rmode = 0;
        new_lsu(2'b11);
        do_txn(2);

        for (int t = 0; t < 30; t++) begin
            if (t == 15) begin
                reset_mid_burst();
                ifu_rw = 2'b10;
                ifu_adr = rand56();
                new_lsu(2'b10);
                do_txn(1);
            end
            if (!ifu_rw[1] && ($urandom % 2) == 0) begin
                ifu_rw = (($urandom % 5) == 0) ? 2'b01 : 2'b10;
                ifu_adr = rand56();
            end
            if (lsu_rw == 2'b00 && ($urandom % 2) == 0)
                new_lsu(2'($urandom_range(1, 3)));
            if (!ifu_rw[1] && lsu_rw == 2'b00)
                new_lsu(2'b10);
            do_txn(2);
        end

        repeat (3) @(negedge clk);
        chk("bq_drained", 512'(bq.size()), 512'(0));
        chk("aq_drained", 512'(aq.size()), 512'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
